ahbl_to_apb: RTL

AHBL_TO_APB -- requirements
Module: ahbl_to_apb

---
 rtl/ahbl_to_apb.sv | 111 +++++++++++
 1 files changed

// File: rtl/ahbl_to_apb.sv
// AHB-lite slave to APB master bridge: one APB access per AHB transfer,
// full-word only, with a two-cycle AHB error response on pslverr.
module ahbl_to_apb #(
  parameter int unsigned W_HADDR = 32,
  parameter int unsigned W_PADDR = 16,
  parameter int unsigned W_DATA  = 32
) (
  input  logic               clk,
  input  logic               rst,

  input  logic               ahbls_hready,
  output logic               ahbls_hready_resp,
  output logic               ahbls_hresp,
  input  logic [W_HADDR-1:0] ahbls_haddr,
  input  logic               ahbls_hwrite,
  input  logic [1:0]         ahbls_htrans,
  input  logic [2:0]         ahbls_hsize,
  input  logic [2:0]         ahbls_hburst,
  input  logic [3:0]         ahbls_hprot,
  input  logic               ahbls_hmastlock,
  input  logic [W_DATA-1:0]  ahbls_hwdata,
  output logic [W_DATA-1:0]  ahbls_hrdata,

  output logic [W_PADDR-1:0] apbm_paddr,
  output logic               apbm_psel,
  output logic               apbm_penable,
  output logic               apbm_pwrite,
  output logic [W_DATA-1:0]  apbm_pwdata,
  input  logic [W_DATA-1:0]  apbm_prdata,
  input  logic               apbm_pready,
  input  logic               apbm_pslverr
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WDATA  = 3'd1,
    SETUP  = 3'd2,
    ACCESS = 3'd3,
    RESP   = 3'd4,
    ERR1   = 3'd5,
    ERR2   = 3'd6
  } state_t;

  state_t state;
  state_t next_state;
  logic   addr_accept;

  // Transfer attributes and the upper address bits are not needed by this bridge.
  logic unused_inputs;
  assign unused_inputs = ^{ahbls_hsize, ahbls_hburst, ahbls_hprot, ahbls_hmastlock,
                           ahbls_haddr, ahbls_htrans[0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state decode; new address phases are taken only in the ready states.
  always_comb begin
    next_state  = state;
    addr_accept = 1'b0;
    case (state)
      IDLE, RESP, ERR2: begin
        next_state = IDLE;
        if (ahbls_hready && ahbls_htrans[1]) begin
          addr_accept = 1'b1;
          next_state  = ahbls_hwrite ? WDATA : SETUP;
        end
      end
      WDATA:   next_state = SETUP;
      SETUP:   next_state = ACCESS;
      ACCESS: begin
        if (apbm_pready) next_state = apbm_pslverr ? ERR1 : RESP;
      end
      ERR1:    next_state = ERR2;
      default: next_state = IDLE;
    endcase
  end

  // Status outputs are registered copies of the decoded next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ahbls_hready_resp <= 1'b1;
      ahbls_hresp       <= 1'b0;
      apbm_psel         <= 1'b0;
      apbm_penable      <= 1'b0;
    end else begin
      ahbls_hready_resp <= next_state inside {IDLE, RESP, ERR2};
      ahbls_hresp       <= next_state inside {ERR1, ERR2};
      apbm_psel         <= next_state inside {SETUP, ACCESS};
      apbm_penable      <= (next_state == ACCESS);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      apbm_paddr   <= '0;
      apbm_pwrite  <= 1'b0;
      apbm_pwdata  <= '0;
      ahbls_hrdata <= '0;
    end else begin
      if (addr_accept) begin
        apbm_paddr  <= ahbls_haddr[W_PADDR-1:0];
        apbm_pwrite <= ahbls_hwrite;
      end
      if (state == WDATA) apbm_pwdata <= ahbls_hwdata;
      if (state == ACCESS && apbm_pready && !apbm_pwrite) ahbls_hrdata <= apbm_prdata;
    end
  end

endmodule
